ctrl_bubble_stage: RTL and testbench

//   ID/EX control pipeline register with hazard bubble insertion, stall hold and flush.

---
 rtl/riscv_pipe_pkg.sv | 20 ++
 rtl/ctrl_bubble_stage_if.sv | 28 ++
 rtl/ctrl_bubble_stage_fsm.sv | 86 ++++++++
 rtl/ctrl_bubble_stage.sv | 82 ++++++++
 tb/tb_ctrl_bubble_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared ID/EX pipeline definitions: control bundle layout and bubble FSM states.
package riscv_pipe_pkg;

    localparam int unsigned CTRL_W_DEFAULT = 12;

    // Control bundle field offsets (LSB of each field)
    localparam int unsigned MEM_WRITE_BIT  = 0;
    localparam int unsigned MEM_READ_BIT   = 1;
    localparam int unsigned MEM_TO_REG_BIT = 2;
    localparam int unsigned REG_WRITE_BIT  = 3;
    localparam int unsigned ALU_SRC_BIT    = 4;
    localparam int unsigned ALU_OP_LSB     = 5;
    localparam int unsigned REG_DST_LSB    = 7;

    typedef enum logic {
        IDLE   = 1'b0,
        BUBBLE = 1'b1
    } state_t;

endpackage

// File: rtl/ctrl_bubble_stage_if.sv
// ID/EX control stage bundle: decoder/hazard inputs and EX-side outputs.
interface ctrl_bubble_stage_if #(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned PERF_W = 16
) ();
    logic [CTRL_W-1:0] ctrl_i;
    logic              valid_i;
    logic              hazard_i;
    logic [CNT_W-1:0]  hazard_len_i;
    logic              stall_i;
    logic              flush_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic              valid_o;
    logic              bubble_o;
    logic              stall_up_o;
    logic [PERF_W-1:0] bubble_cnt_o;

    modport slave (
        input  ctrl_i, valid_i, hazard_i, hazard_len_i, stall_i, flush_i,
        output ctrl_o, valid_o, bubble_o, stall_up_o, bubble_cnt_o
    );

    modport master (
        output ctrl_i, valid_i, hazard_i, hazard_len_i, stall_i, flush_i,
        input  ctrl_o, valid_o, bubble_o, stall_up_o, bubble_cnt_o
    );
endinterface

// File: rtl/ctrl_bubble_stage_fsm.sv
// Bubble sequencer: clamps the requested length and counts out the remaining bubbles.
module hazard_bubble_fsm
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned MAX_BUBBLES = 4,
    parameter int unsigned CNT_W       = $clog2(MAX_BUBBLES + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic             hazard_i,
    input  logic [CNT_W-1:0] hazard_len_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             bubble_sel_c,
    output logic             stall_up_c,
    output logic             perf_inc_c
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_eff;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt holds bubbles still owed after the one being loaded this edge
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bubble_sel_c = 1'b0;
        stall_up_c   = 1'b0;
        perf_inc_c   = 1'b0;

        if (hazard_len_i == '0) begin
            len_eff = CNT_W'(1);
        end else if (hazard_len_i > CNT_W'(MAX_BUBBLES)) begin
            len_eff = CNT_W'(MAX_BUBBLES);
        end else begin
            len_eff = hazard_len_i;
        end

        if (flush_i) begin
            bubble_sel_c = 1'b1;
            state_d      = IDLE;
            cnt_d        = '0;
        end else if (stall_i) begin
            stall_up_c = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hazard_i && valid_i) begin
                        bubble_sel_c = 1'b1;
                        stall_up_c   = 1'b1;
                        perf_inc_c   = 1'b1;
                        if (len_eff != CNT_W'(1)) begin
                            state_d = BUBBLE;
                            cnt_d   = len_eff - CNT_W'(1);
                        end
                    end
                end
                BUBBLE: begin
                    bubble_sel_c = 1'b1;
                    stall_up_c   = 1'b1;
                    perf_inc_c   = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ctrl_bubble_stage.sv
// ID/EX control pipeline register with hazard bubble insertion, stall hold and flush.
module ctrl_bubble_stage
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned       CTRL_W      = CTRL_W_DEFAULT,
    parameter logic [CTRL_W-1:0] KILL_MASK   = '1,
    parameter int unsigned       MAX_BUBBLES = 4,
    parameter int unsigned       CNT_W       = $clog2(MAX_BUBBLES + 1),
    parameter int unsigned       PERF_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    ctrl_bubble_stage_if.slave   bus
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic              bubble_q, bubble_d;
    logic [PERF_W-1:0] perf_q, perf_d;
    logic              bubble_sel_c;
    logic              stall_up_c;
    logic              perf_inc_c;

    hazard_bubble_fsm #(
        .MAX_BUBBLES (MAX_BUBBLES),
        .CNT_W       (CNT_W)
    ) u_fsm (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .valid_i      (bus.valid_i),
        .hazard_i     (bus.hazard_i),
        .hazard_len_i (bus.hazard_len_i),
        .stall_i      (bus.stall_i),
        .flush_i      (bus.flush_i),
        .bubble_sel_c (bubble_sel_c),
        .stall_up_c   (stall_up_c),
        .perf_inc_c   (perf_inc_c)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            bubble_q <= 1'b0;
            perf_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            bubble_q <= bubble_d;
            perf_q   <= perf_d;
        end
    end

    // Bubble (hazard or flush) beats stall hold, which beats normal load
    always_comb begin
        ctrl_d   = ctrl_q;
        valid_d  = valid_q;
        bubble_d = bubble_q;
        perf_d   = perf_q;

        if (bubble_sel_c) begin
            ctrl_d   = bus.ctrl_i & ~KILL_MASK;
            valid_d  = 1'b0;
            bubble_d = 1'b1;
        end else if (!bus.stall_i) begin
            ctrl_d   = bus.ctrl_i;
            valid_d  = bus.valid_i;
            bubble_d = 1'b0;
        end

        if (perf_inc_c && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    assign bus.ctrl_o       = ctrl_q;
    assign bus.valid_o      = valid_q;
    assign bus.bubble_o     = bubble_q;
    assign bus.stall_up_o   = stall_up_c;
    assign bus.bubble_cnt_o = perf_q;

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Table-driven bench for ctrl_bubble_stage with an expected-output queue and a saturating-counter twin.
module tb_ctrl_bubble_stage;

    localparam int unsigned CW  = 12;
    localparam int unsigned MB  = 4;
    localparam int unsigned CNW = $clog2(MB + 1);
    localparam int unsigned PW  = 16;
    localparam int unsigned SPW = 4;

    localparam logic [11:0] A = 12'hA5B;
    localparam logic [11:0] B = 12'hA40;
    localparam logic [11:0] C = 12'h3C7;
    localparam logic [11:0] D = 12'h3C0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctrl_bubble_stage_if #(.CTRL_W(CW), .CNT_W(CNW), .PERF_W(PW))  bus ();
    ctrl_bubble_stage_if #(.CTRL_W(CW), .CNT_W(CNW), .PERF_W(SPW)) sbus ();

    assign sbus.ctrl_i       = bus.ctrl_i;
    assign sbus.valid_i      = bus.valid_i;
    assign sbus.hazard_i     = bus.hazard_i;
    assign sbus.hazard_len_i = bus.hazard_len_i;
    assign sbus.stall_i      = bus.stall_i;
    assign sbus.flush_i      = bus.flush_i;

    ctrl_bubble_stage #(
        .CTRL_W(CW), .KILL_MASK(12'h01F), .MAX_BUBBLES(MB), .CNT_W(CNW), .PERF_W(PW)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    ctrl_bubble_stage #(
        .CTRL_W(CW), .KILL_MASK(12'h01F), .MAX_BUBBLES(MB), .CNT_W(CNW), .PERF_W(SPW)
    ) dut_sat (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (sbus)
    );

    typedef struct {
        logic [11:0] ctrl;
        logic        valid;
        logic        hazard;
        logic [2:0]  len;
        logic        stall;
        logic        flush;
        logic [11:0] e_ctrl;
        logic        e_valid;
        logic        e_bub;
        logic        e_su;
        int          e_cnt;
    } vec_t;

    typedef struct {
        logic [11:0] ctrl;
        logic        valid;
        logic        bub;
        int          cnt;
        int          idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic [11:0] c, logic v, logic h, logic [2:0] l, logic s, logic f,
                                logic [11:0] ec, logic ev, logic eb, logic esu, int ecnt);
        vec_t r;
        r.ctrl = c; r.valid = v; r.hazard = h; r.len = l; r.stall = s; r.flush = f;
        r.e_ctrl = ec; r.e_valid = ev; r.e_bub = eb; r.e_su = esu; r.e_cnt = ecnt;
        return r;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Drive one vector mid-cycle, check the combinational stall, then the registered result
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        int   sat_exp;
        @(negedge clk);
        bus.ctrl_i       = v.ctrl;
        bus.valid_i      = v.valid;
        bus.hazard_i     = v.hazard;
        bus.hazard_len_i = v.len;
        bus.stall_i      = v.stall;
        bus.flush_i      = v.flush;
        #1;
        check("stall_up_o", idx, 32'(bus.stall_up_o), 32'(v.e_su));
        e.ctrl = v.e_ctrl; e.valid = v.e_valid; e.bub = v.e_bub; e.cnt = v.e_cnt; e.idx = idx;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        n_vec++;
        if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard vec %0d: got empty queue expected entry", idx);
        end else begin
            e = sbq.pop_front();
            sat_exp = (e.cnt > 15) ? 15 : e.cnt;
            check("ctrl_o",       e.idx, 32'(bus.ctrl_o),        32'(e.ctrl));
            check("valid_o",      e.idx, 32'(bus.valid_o),       32'(e.valid));
            check("bubble_o",     e.idx, 32'(bus.bubble_o),      32'(e.bub));
            check("bubble_cnt_o", e.idx, 32'(bus.bubble_cnt_o),  32'(e.cnt));
            check("sat_cnt",      e.idx, 32'(sbus.bubble_cnt_o), 32'(sat_exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int base;
        bus.ctrl_i = '0; bus.valid_i = 0; bus.hazard_i = 0;
        bus.hazard_len_i = '0; bus.stall_i = 0; bus.flush_i = 0;

        // pass-through, single bubble, length clamp (3, 7->4, 0->1)
        tbl.push_back(mk(A,1,0,0,0,0, A,1,0,0,0));
        tbl.push_back(mk(A,1,1,1,0,0, B,0,1,1,1));
        tbl.push_back(mk(A,1,0,0,0,0, A,1,0,0,1));
        tbl.push_back(mk(A,1,1,3,0,0, B,0,1,1,2));
        tbl.push_back(mk(A,1,1,3,0,0, B,0,1,1,3));
        tbl.push_back(mk(A,1,1,3,0,0, B,0,1,1,4));
        tbl.push_back(mk(A,1,0,3,0,0, A,1,0,0,4));
        tbl.push_back(mk(A,1,1,7,0,0, B,0,1,1,5));
        tbl.push_back(mk(A,1,1,7,0,0, B,0,1,1,6));
        tbl.push_back(mk(A,1,1,7,0,0, B,0,1,1,7));
        tbl.push_back(mk(A,1,1,7,0,0, B,0,1,1,8));
        tbl.push_back(mk(A,1,0,0,0,0, A,1,0,0,8));
        tbl.push_back(mk(C,1,1,0,0,0, D,0,1,1,9));
        tbl.push_back(mk(C,1,0,0,0,0, C,1,0,0,9));
        // stall two cycles after first bubble of a 3-bubble hazard
        tbl.push_back(mk(A,1,1,3,0,0, B,0,1,1,10));
        tbl.push_back(mk(12'h123,1,1,3,1,0, B,0,1,1,10));
        tbl.push_back(mk(12'h123,1,1,3,1,0, B,0,1,1,10));
        tbl.push_back(mk(A,1,1,3,0,0, B,0,1,1,11));
        tbl.push_back(mk(A,1,1,3,0,0, B,0,1,1,12));
        tbl.push_back(mk(A,1,0,0,0,0, A,1,0,0,12));
        // flush after second bubble of a 4-bubble hazard
        tbl.push_back(mk(A,1,1,4,0,0, B,0,1,1,13));
        tbl.push_back(mk(A,1,1,4,0,0, B,0,1,1,14));
        tbl.push_back(mk(A,1,1,4,0,1, B,0,1,0,14));
        tbl.push_back(mk(A,1,0,0,0,0, A,1,0,0,14));
        // flush beats stall; stall in IDLE holds; hazard on invalid slot ignored
        tbl.push_back(mk(C,1,0,0,1,1, D,0,1,0,14));
        tbl.push_back(mk(A,1,0,0,1,0, D,0,1,1,14));
        tbl.push_back(mk(A,0,1,3,0,0, A,0,0,0,14));
        tbl.push_back(mk(12'hFFF,1,0,0,0,0, 12'hFFF,1,0,0,14));

        #12;
        check("reset ctrl_o",       -1, 32'(bus.ctrl_o),       32'h0);
        check("reset valid_o",      -1, 32'(bus.valid_o),      32'h0);
        check("reset bubble_o",     -1, 32'(bus.bubble_o),     32'h0);
        check("reset bubble_cnt_o", -1, 32'(bus.bubble_cnt_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Drive the 4-bit twin past saturation
        cnt  = 14;
        base = tbl.size();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                cnt++;
                apply(mk(A,1,1,4,0,0, B,0,1,1,cnt), base + r*5 + k);
            end
            apply(mk(A,1,0,0,0,0, A,1,0,0,cnt), base + r*5 + 4);
        end
        check("main_cnt_22", base + 10, 32'(bus.bubble_cnt_o), 32'd22);

        // Async reset in the middle of a bubble sequence
        apply(mk(A,1,1,4,0,0, B,0,1,1,23), 100);
        @(negedge clk);
        bus.hazard_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst ctrl_o",       101, 32'(bus.ctrl_o),        32'h0);
        check("arst valid_o",      101, 32'(bus.valid_o),       32'h0);
        check("arst bubble_o",     101, 32'(bus.bubble_o),      32'h0);
        check("arst stall_up_o",   101, 32'(bus.stall_up_o),    32'h0);
        check("arst bubble_cnt_o", 101, 32'(bus.bubble_cnt_o),  32'h0);
        check("arst sat_cnt",      101, 32'(sbus.bubble_cnt_o), 32'h0);
        #2;
        rst_n = 1'b1;
        apply(mk(A,1,0,0,0,0, A,1,0,0,0), 102);
        apply(mk(A,1,1,1,0,0, B,0,1,1,1), 103);
        apply(mk(A,1,0,0,0,0, A,1,0,0,1), 104);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
